// File: rtl/uart_rx_line_filter.sv
// UART RX pin conditioner: synchroniser, consecutive-sample debounce, edge pulses,
// glitch counter and optional line-break detector (enabled by `UART_RX_BREAK_DETECT_EN).
module uart_rx_line_filter #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 clk_i,
    input  logic                 arst_ni,
    input  logic                 sample_en_i,
    input  logic                 rx_i,
    output logic                 rx_o,
    output logic                 fall_o,
    output logic                 rise_o,
    input  logic                 glitch_clr_i,
    output logic [7:0]           glitch_cnt_o,
    input  logic [CNT_WIDTH-1:0] break_len_i,
    output logic                 break_o,
    output logic                 break_det_o
);

    localparam int unsigned STAB_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [STAB_W-1:0]      stab_q;
    logic [STAB_W-1:0]      stab_d;
    logic                   rx_d;
    logic                   fall_d;
    logic                   rise_d;
    logic                   glitch_inc;
    logic [7:0]             glitch_d;

    // Synchroniser chain; idles high so reset does not look like a start bit
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Debounce: a run of FILT_LEN differing samples flips the line; a broken run is a glitch
    always_comb begin
        stab_d     = stab_q;
        rx_d       = rx_o;
        fall_d     = 1'b0;
        rise_d     = 1'b0;
        glitch_inc = 1'b0;
        if (sample_en_i) begin
            if (s == rx_o) begin
                if (stab_q != '0) begin
                    glitch_inc = 1'b1;
                    stab_d     = '0;
                end
            end else if (stab_q == STAB_LAST) begin
                rx_d   = s;
                stab_d = '0;
                fall_d = ~s;
                rise_d = s;
            end else begin
                stab_d = stab_q + STAB_W'(1);
            end
        end
    end

    always_comb begin
        glitch_d = glitch_cnt_o;
        if (glitch_clr_i) begin
            glitch_d = 8'd0;
        end else if (glitch_inc && (glitch_cnt_o != 8'hFF)) begin
            glitch_d = glitch_cnt_o + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            stab_q       <= '0;
            rx_o         <= 1'b1;
            fall_o       <= 1'b0;
            rise_o       <= 1'b0;
            glitch_cnt_o <= 8'd0;
        end else begin
            stab_q       <= stab_d;
            rx_o         <= rx_d;
            fall_o       <= fall_d;
            rise_o       <= rise_d;
            glitch_cnt_o <= glitch_d;
        end
    end

`ifdef UART_RX_BREAK_DETECT_EN
    logic [CNT_WIDTH-1:0] brk_q;
    logic [CNT_WIDTH-1:0] brk_d;
    logic [CNT_WIDTH-1:0] brk_inc;
    logic                 break_d;
    logic                 break_det_d;

    assign brk_inc = (brk_q == '1) ? brk_q : brk_q + CNT_WIDTH'(1);

    // Break is sticky for the whole low period and clears on the same edge as rise_o
    always_comb begin
        brk_d       = brk_q;
        break_d     = break_o;
        break_det_d = 1'b0;
        if (rise_d) begin
            brk_d   = '0;
            break_d = 1'b0;
        end else if (sample_en_i && !rx_o) begin
            brk_d = brk_inc;
            if (!break_o && (break_len_i != '0) && (brk_inc >= break_len_i)) begin
                break_d     = 1'b1;
                break_det_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            brk_q       <= '0;
            break_o     <= 1'b0;
            break_det_o <= 1'b0;
        end else begin
            brk_q       <= brk_d;
            break_o     <= break_d;
            break_det_o <= break_det_d;
        end
    end
`else
    logic unused_break_len;

    assign unused_break_len = ^break_len_i;
    assign break_o          = 1'b0;
    assign break_det_o      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_line_filter.sv
// Self-checking bench for uart_rx_line_filter: table-driven pulse widths plus
// hand-written sequences; rx_o edges are matched against a queue of expected edges.
module tb_uart_rx_line_filter;

    localparam int unsigned SYNC = 2;
    localparam int unsigned FILT = 4;
    localparam int unsigned LAT  = SYNC + FILT;
`ifdef UART_RX_BREAK_DETECT_EN
    localparam bit BRK = 1'b1;
`else
    localparam bit BRK = 1'b0;
`endif

    typedef struct {
        logic lvl;
        int   cyc;
    } edge_t;

    typedef struct {
        int unsigned low_len;
        bit          passes;
    } vec_t;

    logic        clk = 1'b0;
    logic        arst_ni;
    logic        sample_en;
    logic        rx;
    logic        rx_f;
    logic        fall;
    logic        rise;
    logic        glitch_clr;
    logic [7:0]  glitch_cnt;
    logic [15:0] break_len;
    logic        brk;
    logic        brk_det;

    int    cyc = 0;
    int    n_vec = 0;
    int    n_err = 0;
    edge_t sb_q[$];

    uart_rx_line_filter #(
        .SYNC_STAGES(SYNC),
        .FILT_LEN   (FILT),
        .CNT_WIDTH  (16)
    ) dut (
        .clk_i       (clk),
        .arst_ni     (arst_ni),
        .sample_en_i (sample_en),
        .rx_i        (rx),
        .rx_o        (rx_f),
        .fall_o      (fall),
        .rise_o      (rise),
        .glitch_clr_i(glitch_clr),
        .glitch_cnt_o(glitch_cnt),
        .break_len_i (break_len),
        .break_o     (brk),
        .break_det_o (brk_det)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_edge(input logic lvl, input int at);
        edge_t e;
        e.lvl = lvl;
        e.cyc = at;
        sb_q.push_back(e);
    endtask

    // Any pulse on fall/rise must match the oldest expected edge
    task automatic sb_check();
        edge_t e;
        if (fall || rise) begin
            n_vec++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_edge: fall=%0b rise=%0b rx_o=%0b, none expected (cyc %0d)",
                         fall, rise, rx_f, cyc);
            end else begin
                e = sb_q.pop_front();
                if ((rx_f !== e.lvl) || (fall !== !e.lvl) || (rise !== e.lvl) ||
                    ((e.cyc >= 0) && (e.cyc != cyc))) begin
                    n_err++;
                    $display("FAIL sb_edge: got rx_o=%0b fall=%0b rise=%0b at cyc %0d, expected level %0b at cyc %0d",
                             rx_f, fall, rise, cyc, e.lvl, e.cyc);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        sb_check();
    endtask

    initial begin
        vec_t        vecs[7];
        int          n0;
        int          r0;
        logic [7:0]  exp_gc;
        int          det_cnt;

        vecs[0] = '{1, 1'b0};
        vecs[1] = '{2, 1'b0};
        vecs[2] = '{3, 1'b0};
        vecs[3] = '{4, 1'b1};
        vecs[4] = '{5, 1'b1};
        vecs[5] = '{3, 1'b0};
        vecs[6] = '{8, 1'b1};

        arst_ni    = 1'b0;
        rx         = 1'b1;
        sample_en  = 1'b1;
        glitch_clr = 1'b0;
        break_len  = 16'd10;
        @(negedge clk);
        @(negedge clk);
        chk1("rst_rx", rx_f, 1'b1);
        chk1("rst_fall", fall, 1'b0);
        chk1("rst_rise", rise, 1'b0);
        chk8("rst_gc", glitch_cnt, 8'd0);
        chk1("rst_brk", brk, 1'b0);
        arst_ni = 1'b1;

        // Idle line
        for (int i = 0; i < 20; i++) begin
            tick();
            chk1("idle_rx", rx_f, 1'b1);
            chk8("idle_gc", glitch_cnt, 8'd0);
        end

        // Clean fall: visible exactly LAT edges after the change
        n0 = cyc;
        rx = 1'b0;
        push_edge(1'b0, n0 + int'(LAT));
        repeat (LAT - 1) tick();
        chk1("fall_early_rx", rx_f, 1'b1);
        tick();
        chk1("fall_rx", rx_f, 1'b0);
        chk1("fall_pulse", fall, 1'b1);
        tick();
        chk1("fall_pulse_end", fall, 1'b0);
        r0 = cyc;
        rx = 1'b1;
        push_edge(1'b1, r0 + int'(LAT));
        repeat (10) tick();
        chk1("rise_done_rx", rx_f, 1'b1);

        // Table: pulse widths around the reject window
        exp_gc = 8'd0;
        for (int v = 0; v < 7; v++) begin
            n0 = cyc;
            rx = 1'b0;
            if (vecs[v].passes) begin
                push_edge(1'b0, n0 + int'(LAT));
                push_edge(1'b1, n0 + int'(vecs[v].low_len + LAT));
            end else begin
                exp_gc = exp_gc + 8'd1;
            end
            repeat (vecs[v].low_len) tick();
            rx = 1'b1;
            repeat (12) tick();
            chk1("tbl_rx", rx_f, 1'b1);
            chk8("tbl_gc", glitch_cnt, exp_gc);
        end

        // Five 3-cycle glitches from a cleared count
        glitch_clr = 1'b1;
        tick();
        glitch_clr = 1'b0;
        chk8("clr_gc", glitch_cnt, 8'd0);
        for (int g = 0; g < 5; g++) begin
            rx = 1'b0;
            repeat (3) tick();
            rx = 1'b1;
            repeat (8) tick();
            chk1("glitch5_rx", rx_f, 1'b1);
        end
        chk8("glitch5_gc", glitch_cnt, 8'd5);

        // Sixth glitch: clear coincides with the abort edge
        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        repeat (2) tick();
        glitch_clr = 1'b1;
        tick();
        glitch_clr = 1'b0;
        chk8("clr_vs_inc_gc", glitch_cnt, 8'd0);
        repeat (4) tick();
        chk8("clr_hold_gc", glitch_cnt, 8'd0);

        // Sparse sample enable: fall on the 4th qualified sample
        sample_en = 1'b0;
        rx        = 1'b0;
        push_edge(1'b0, -1);
        repeat (4) tick();
        for (int k = 1; k <= 6; k++) begin
            for (int j = 0; j < 7; j++) begin
                tick();
                chk1("en_hold_rx", rx_f, (k - 1 >= 4) ? 1'b0 : 1'b1);
                chk1("en_hold_fall", fall, 1'b0);
            end
            sample_en = 1'b1;
            tick();
            sample_en = 1'b0;
            chk1("en_q_rx", rx_f, (k >= 4) ? 1'b0 : 1'b1);
            chk1("en_q_fall", fall, (k == 4) ? 1'b1 : 1'b0);
        end
        chk8("en_gc", glitch_cnt, 8'd0);
        sample_en = 1'b1;
        r0 = cyc;
        rx = 1'b1;
        push_edge(1'b1, r0 + int'(LAT));
        repeat (10) tick();

        // Break with threshold 10, then disabled threshold
        for (int pass = 0; pass < 2; pass++) begin
            break_len = (pass == 0) ? 16'd10 : 16'd0;
            n0 = cyc;
            rx = 1'b0;
            push_edge(1'b0, n0 + int'(LAT));
            det_cnt = 0;
            for (int i = 1; i <= 25; i++) begin
                tick();
                if (brk_det) det_cnt++;
                chk1("brk_level", brk, BRK && (pass == 0) && (cyc >= n0 + int'(LAT) + 10));
                chk1("brk_det", brk_det, BRK && (pass == 0) && (cyc == n0 + int'(LAT) + 10));
            end
            chk8("brk_det_count", 8'(det_cnt), (BRK && (pass == 0)) ? 8'd1 : 8'd0);
            r0 = cyc;
            rx = 1'b1;
            push_edge(1'b1, r0 + int'(LAT));
            for (int i = 1; i <= 8; i++) begin
                tick();
                chk1("brk_release", brk, BRK && (pass == 0) && (cyc < r0 + int'(LAT)));
            end
        end

        // Lowering the threshold below the running count
        break_len = 16'd40;
        n0 = cyc;
        rx = 1'b0;
        push_edge(1'b0, n0 + int'(LAT));
        repeat (LAT + 14) tick();
        chk1("brk_lower_pre", brk, 1'b0);
        break_len = 16'd5;
        tick();
        chk1("brk_lower_lvl", brk, BRK);
        chk1("brk_lower_det", brk_det, BRK);
        r0 = cyc;
        rx = 1'b1;
        push_edge(1'b1, r0 + int'(LAT));
        repeat (10) tick();
        break_len = 16'd10;

        // Glitch counter saturation
        for (int g = 0; g < 300; g++) begin
            rx = 1'b0;
            tick();
            rx = 1'b1;
            repeat (3) tick();
            if (g == 99) chk8("sat_mid_gc", glitch_cnt, 8'd100);
        end
        repeat (6) tick();
        chk8("sat_gc", glitch_cnt, 8'd255);
        chk1("sat_rx", rx_f, 1'b1);

        // Asynchronous reset in the middle of a break
        n0 = cyc;
        rx = 1'b0;
        push_edge(1'b0, n0 + int'(LAT));
        repeat (20) tick();
        chk1("pre_rst_brk", brk, BRK);
        arst_ni = 1'b0;
        #1;
        chk1("arst_rx", rx_f, 1'b1);
        chk1("arst_fall", fall, 1'b0);
        chk1("arst_rise", rise, 1'b0);
        chk8("arst_gc", glitch_cnt, 8'd0);
        chk1("arst_brk", brk, 1'b0);
        chk1("arst_det", brk_det, 1'b0);
        if (sb_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_pending_at_reset: %0d edges outstanding, expected 0", sb_q.size());
            sb_q.delete();
        end
        rx = 1'b1;
        repeat (2) tick();
        arst_ni = 1'b1;
        repeat (10) tick();
        chk1("post_rst_rx", rx_f, 1'b1);
        chk1("post_rst_brk", brk, 1'b0);

        // Normal operation after reset
        n0 = cyc;
        rx = 1'b0;
        push_edge(1'b0, n0 + int'(LAT));
        repeat (10) tick();
        chk1("post_rst_fall_rx", rx_f, 1'b0);
        r0 = cyc;
        rx = 1'b1;
        push_edge(1'b1, r0 + int'(LAT));
        repeat (10) tick();
        chk1("post_rst_rise_rx", rx_f, 1'b1);
        chk8("post_rst_gc", glitch_cnt, 8'd0);

        // Every expected edge must have been produced
        n_vec++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_missing_edges: %0d edges never seen, expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
